note_track_sequencer: RTL and testbench

Controller for the Guitar Hero note lane. It paces the game from `CLOCK_50` with a divided tick, fetches 4-bit note patterns from the preloaded track RAM, and feeds them into an internal 8-stage note track. The track advances one stage per tick and is loaded in parallel every fourth tick. It replaces the free-running counter and shift chain in the game top level with one sequenced block that has defined start, pause and end-of-song behaviour.

---
 rtl/note_track_sequencer_pkg.sv | 19 +
 rtl/note_track_sequencer_if.sv | 17 +
 rtl/note_track_sequencer_tick.sv | 44 ++++
 rtl/note_track_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_note_track_sequencer.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/note_track_sequencer_pkg.sv
// Shared definitions for the note track sequencer.
// Holds the controller state enum and the widths of the pattern word,
// the note lane and the track RAM address.
package note_track_sequencer_pkg;

  localparam int PATTERN_W        = 4;
  localparam int TRACK_W          = 8;
  localparam int ADDR_W           = 7;
  localparam int ROWS_PER_PATTERN = 4;

  typedef enum logic [2:0] {
    NTS_IDLE     = 3'd0,
    NTS_PREFETCH = 3'd1,
    NTS_RUN      = 3'd2,
    NTS_DRAIN    = 3'd3,
    NTS_DONE     = 3'd4
  } nts_state_e;

endpackage

// File: rtl/note_track_sequencer_if.sv
// Track RAM read bus between the sequencer (master) and the RAM (slave).
//   ram_addr : read address driven by the sequencer
//   ram_q    : pattern word returned by the RAM
// Bus protocol: there is no valid/ready pair. The RAM is always ready;
// ram_q is valid RAM_LAT cycles after ram_addr changes and stays valid
// while ram_addr is held. The master only samples ram_q after holding
// the address for at least RAM_LAT cycles.
interface note_track_sequencer_if;
  import note_track_sequencer_pkg::*;

  logic [ADDR_W-1:0]    ram_addr;
  logic [PATTERN_W-1:0] ram_q;

  modport master (output ram_addr, input ram_q);
  modport slave  (input ram_addr, output ram_q);

endinterface

// File: rtl/note_track_sequencer_tick.sv
// Game tick divider.
// Ports:
//   clk, rst : clock and asynchronous active-high reset
//   enable   : counting allowed; when low the count is cleared
//   pause    : holds the count and suppresses the tick
//   tick     : combinational strobe in the cycle the count wraps
//              (the owner registers it together with its lane update)
module tick_divider #(
  parameter int TICK_DIV = 12_500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic pause,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (!enable) begin
      cnt_d = '0;
    end else if (!pause) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        tick  = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/note_track_sequencer.sv
// Guitar Hero note lane controller.
// Paces the game with a divided tick, fetches 4-bit patterns from the
// track RAM and shifts them through an 8-row lane (track[0] = hit row).
// Ports:
//   CLOCK_50, RESET_GAME : clock, asynchronous active-high reset
//   start                : one-cycle pulse, starts a song from IDLE/DONE
//   pause                : level, freezes the game tick
//   ram_bus              : track RAM read bus (master side)
//   track                : note lane
//   tick, load_pulse     : registered pulses on lane advance / pattern load
//   playing, done        : song status
//   dbg_state            : current controller state
module note_track_sequencer
  import note_track_sequencer_pkg::*;
#(
  parameter int TICK_DIV = 12_500_000,
  parameter int SONG_LEN = 128,
  parameter int RAM_LAT  = 1
) (
  input  logic                  CLOCK_50,
  input  logic                  RESET_GAME,
  input  logic                  start,
  input  logic                  pause,
  note_track_sequencer_if.master ram_bus,
  output logic [TRACK_W-1:0]    track,
  output logic                  tick,
  output logic                  load_pulse,
  output logic                  playing,
  output logic                  done,
  output nts_state_e            dbg_state
);

  localparam int PHASE_W = $clog2(ROWS_PER_PATTERN);
  localparam logic [PHASE_W-1:0] PHASE_ONE = PHASE_W'(1);
  localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(SONG_LEN - 1);
  localparam logic [ADDR_W-1:0]  ADDR_ONE  = ADDR_W'(1);
  localparam logic [1:0]         LAT       = 2'(RAM_LAT);
  localparam logic [1:0]         LAT_M1    = 2'(RAM_LAT - 1);

  nts_state_e           state_q, state_d;
  logic [PHASE_W-1:0]   phase_q, phase_d;
  logic [PATTERN_W-1:0] pending_q, pending_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [TRACK_W-1:0]   track_q, track_d;
  logic                 tick_q, tick_d;
  logic                 load_q, load_d;
  logic [1:0]           wait_q, wait_d;
  logic                 fetch_busy_q, fetch_busy_d;
  logic                 last_fetched_q, last_fetched_d;  // pattern SONG_LEN-1 is in pending
  logic                 last_loaded_q, last_loaded_d;    // pattern SONG_LEN-1 is in the lane
  logic                 drain_seen_q, drain_seen_d;      // one phase-0 tick already spent in DRAIN
  logic                 tick_strobe;

  tick_divider #(.TICK_DIV(TICK_DIV)) u_tick_divider (
    .clk    (CLOCK_50),
    .rst    (RESET_GAME),
    .enable ((state_q == NTS_RUN) || (state_q == NTS_DRAIN)),
    .pause  (pause),
    .tick   (tick_strobe)
  );

  always_comb begin
    state_d        = state_q;
    phase_d        = phase_q;
    pending_d      = pending_q;
    addr_d         = addr_q;
    track_d        = track_q;
    tick_d         = 1'b0;
    load_d         = 1'b0;
    wait_d         = wait_q;
    fetch_busy_d   = fetch_busy_q;
    last_fetched_d = last_fetched_q;
    last_loaded_d  = last_loaded_q;
    drain_seen_d   = drain_seen_q;

    unique case (state_q)
      NTS_IDLE, NTS_DONE: begin
        if (start) begin
          state_d        = NTS_PREFETCH;
          track_d        = '0;
          addr_d         = '0;
          pending_d      = '0;
          phase_d        = '0;
          wait_d         = '0;
          fetch_busy_d   = 1'b0;
          last_fetched_d = 1'b0;
          last_loaded_d  = 1'b0;
          drain_seen_d   = 1'b0;
        end
      end

      NTS_PREFETCH: begin
        // The address was just cleared, so allow one cycle beyond RAM_LAT.
        if (wait_q == LAT) begin
          pending_d = ram_bus.ram_q;
          if (addr_q == LAST_ADDR) last_fetched_d = 1'b1;
          else                     addr_d = addr_q + ADDR_ONE;
          state_d = NTS_RUN;
          phase_d = '0;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end

      NTS_RUN, NTS_DRAIN: begin
        // Background fetch; the address has been stable since the
        // previous fetch, so it lands well before the next load tick.
        if (fetch_busy_q) begin
          if (wait_q == LAT_M1) begin
            pending_d    = ram_bus.ram_q;
            fetch_busy_d = 1'b0;
            if (addr_q == LAST_ADDR) last_fetched_d = 1'b1;
            else                     addr_d = addr_q + ADDR_ONE;
          end else begin
            wait_d = wait_q + 2'd1;
          end
        end

        if (tick_strobe) begin
          tick_d  = 1'b1;
          phase_d = phase_q + PHASE_ONE;
          if (phase_q == '0) begin
            track_d = {pending_q, track_q[TRACK_W-PATTERN_W:1]};
            load_d  = 1'b1;
            if (state_q == NTS_DRAIN) begin
              // Second phase-0 tick in DRAIN: the last pattern has left the lane.
              if (drain_seen_q && (track_q == '0)) state_d = NTS_DONE;
              else                                 drain_seen_d = 1'b1;
            end else if (last_loaded_q) begin
              state_d = NTS_DRAIN;
            end else if (last_fetched_q) begin
              last_loaded_d = 1'b1;
              pending_d     = '0;
            end else begin
              fetch_busy_d = 1'b1;
              wait_d       = '0;
            end
          end else begin
            track_d = {1'b0, track_q[TRACK_W-1:1]};
          end
        end
      end

      default: state_d = NTS_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge RESET_GAME) begin
    if (RESET_GAME) begin
      state_q        <= NTS_IDLE;
      phase_q        <= '0;
      pending_q      <= '0;
      addr_q         <= '0;
      track_q        <= '0;
      tick_q         <= 1'b0;
      load_q         <= 1'b0;
      wait_q         <= '0;
      fetch_busy_q   <= 1'b0;
      last_fetched_q <= 1'b0;
      last_loaded_q  <= 1'b0;
      drain_seen_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      phase_q        <= phase_d;
      pending_q      <= pending_d;
      addr_q         <= addr_d;
      track_q        <= track_d;
      tick_q         <= tick_d;
      load_q         <= load_d;
      wait_q         <= wait_d;
      fetch_busy_q   <= fetch_busy_d;
      last_fetched_q <= last_fetched_d;
      last_loaded_q  <= last_loaded_d;
      drain_seen_q   <= drain_seen_d;
    end
  end

  assign ram_bus.ram_addr = addr_q;
  assign track            = track_q;
  assign tick             = tick_q;
  assign load_pulse       = load_q;
  assign playing          = (state_q == NTS_PREFETCH) || (state_q == NTS_RUN) ||
                            (state_q == NTS_DRAIN);
  assign done             = (state_q == NTS_DONE);
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_note_track_sequencer.sv
module tb_note_track_sequencer;
  import note_track_sequencer_pkg::*;

  localparam int TICK_DIV = 4;
  localparam int SONG_LEN = 3;
  localparam int RAM_LAT  = 1;

  localparam int M_IDLE = 0;
  localparam int M_PRE  = 1;
  localparam int M_ACT  = 2;
  localparam int M_DONE = 3;

  // ---------------- clock / reset ----------------
  logic       CLOCK_50 = 1'b0;
  logic       RESET_GAME = 1'b1;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic [7:0] track;
  logic       tick, load_pulse, playing, done;
  nts_state_e dbg_state;

  always #5 CLOCK_50 = ~CLOCK_50;

  note_track_sequencer_if ram_if ();

  note_track_sequencer #(
    .TICK_DIV(TICK_DIV), .SONG_LEN(SONG_LEN), .RAM_LAT(RAM_LAT)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .RESET_GAME (RESET_GAME),
    .start      (start),
    .pause      (pause),
    .ram_bus    (ram_if),
    .track      (track),
    .tick       (tick),
    .load_pulse (load_pulse),
    .playing    (playing),
    .done       (done),
    .dbg_state  (dbg_state)
  );

  // Track RAM with one cycle of read latency.
  logic [3:0] mem [0:127];
  always @(posedge CLOCK_50) ram_if.ram_q <= mem[ram_if.ram_addr];

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Abstract view: a song is a list of patterns; pattern j enters the top
  // half of the lane on tick 4j and moves down one row per tick.
  int   m_mode, m_pw, m_u, m_k, m_f;
  bit   m_fetch_due;
  logic [7:0] m_track;
  logic m_tick, m_load;

  function automatic logic [7:0] lane_after(int k);
    logic [7:0] acc;
    logic [7:0] nib;
    acc = '0;
    for (int j = 0; j < SONG_LEN; j++) begin
      if ((4 * j <= k) && (k - 4 * j < 8)) begin
        nib = {mem[j], 4'b0000};
        acc = acc | (nib >> (k - 4 * j));
      end
    end
    return acc;
  endfunction

  function automatic int exp_addr();
    return (m_f < SONG_LEN - 1) ? m_f : SONG_LEN - 1;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_pw = 0; m_u = 0; m_k = 0; m_f = 0;
    m_fetch_due = 1'b0; m_track = '0; m_tick = 1'b0; m_load = 1'b0;
  endtask

  task automatic model_edge(input logic st, input logic pz);
    m_tick = 1'b0;
    m_load = 1'b0;
    case (m_mode)
      M_IDLE, M_DONE: begin
        if (st) begin
          m_mode = M_PRE; m_pw = RAM_LAT + 1; m_track = '0;
          m_f = 0; m_fetch_due = 1'b0;
        end
      end
      M_PRE: begin
        m_pw--;
        if (m_pw == 0) begin
          m_mode = M_ACT; m_f = 1; m_u = 0; m_k = 0;
        end
      end
      M_ACT: begin
        if (m_fetch_due) begin
          m_f++;
          m_fetch_due = 1'b0;
        end
        if (!pz) begin
          m_u++;
          if (m_u == TICK_DIV) begin
            m_u = 0;
            m_tick = 1'b1;
            m_load = (m_k % 4 == 0);
            m_track = lane_after(m_k);
            if (m_load) m_fetch_due = 1'b1;
            if (m_k == 4 * SONG_LEN + 8) m_mode = M_DONE;
            m_k++;
          end
        end
      end
      default: m_mode = M_IDLE;
    endcase
  endtask

  task automatic compare_all();
    check_eq("tick", tick, m_tick);
    check_eq("load_pulse", load_pulse, m_load);
    check_eq("track", track, m_track);
    check_eq("ram_addr", ram_if.ram_addr, exp_addr());
    check_eq("playing", playing, (m_mode == M_PRE) || (m_mode == M_ACT));
    check_eq("done", done, m_mode == M_DONE);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic st, input logic pz);
    @(negedge CLOCK_50);
    start = st;
    pause = pz;
    model_edge(st, pz);
    @(posedge CLOCK_50);
    #1;
    start = 1'b0;
    compare_all();
  endtask

  task automatic wait_tick(input int limit);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      step(1'b0, 1'b0);
      if (tick) seen = 1'b1;
    end
    check_eq("tick_seen", seen, 1'b1);
  endtask

  task automatic wait_done(input int limit);
    for (int i = 0; i < limit && !done; i++) step(1'b0, 1'b0);
    check_eq("done_reached", done, 1'b1);
  endtask

  task automatic apply_reset();
    @(negedge CLOCK_50);
    RESET_GAME = 1'b1;
    start = 1'b0;
    pause = 1'b0;
    model_reset();
    repeat (3) @(negedge CLOCK_50);
    RESET_GAME = 1'b0;
    #1;
    compare_all();
    check_eq("reset_state", dbg_state, NTS_IDLE);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  logic [7:0] saved_track;

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 4'h0;
    mem[0] = 4'b1001;
    mem[1] = 4'b0110;
    mem[2] = 4'b1111;
    model_reset();
    apply_reset();

    // First song: load ticks and lane shifting.
    step(1'b1, 1'b0);
    check_eq("prefetch_state", dbg_state, NTS_PREFETCH);
    wait_tick(20);
    check_eq("first_track", track, 8'b1001_0000);
    check_eq("first_load", load_pulse, 1'b1);
    check_eq("first_addr", ram_if.ram_addr, 7'd1);
    repeat (3) wait_tick(20);
    check_eq("shift3_track", track, 8'b0001_0010);
    wait_tick(20);
    check_eq("second_track", track, 8'b0110_1001);
    check_eq("second_load", load_pulse, 1'b1);
    check_eq("second_addr", ram_if.ram_addr, 7'd2);

    // Pause for 20 cycles mid-RUN, two unpaused cycles after a tick.
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    saved_track = track;
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1);
    check_eq("pause_track", track, saved_track);
    step(1'b0, 1'b0);
    check_eq("pause_no_early_tick", tick, 1'b0);
    step(1'b0, 1'b0);
    check_eq("pause_resume_tick", tick, 1'b1);

    // start during RUN is ignored.
    step(1'b1, 1'b0);
    check_eq("start_in_run", dbg_state, NTS_RUN);

    wait_done(400);
    check_eq("end_playing", playing, 1'b0);
    check_eq("end_track", track, 8'h00);
    check_eq("end_addr", ram_if.ram_addr, 7'd2);

    // start in DONE restarts the song.
    step(1'b1, 1'b0);
    check_eq("restart_state", dbg_state, NTS_PREFETCH);
    check_eq("restart_addr", ram_if.ram_addr, 7'd0);
    wait_tick(20);
    check_eq("restart_track", track, 8'b1001_0000);

    // Reset while the background fetch after this load tick is in flight.
    RESET_GAME = 1'b1;
    model_reset();
    #1;
    compare_all();
    check_eq("midfetch_reset_state", dbg_state, NTS_IDLE);
    @(negedge CLOCK_50);
    RESET_GAME = 1'b0;
    step(1'b1, 1'b0);
    wait_tick(20);
    check_eq("replay_track", track, 8'b1001_0000);
    check_eq("replay_addr", ram_if.ram_addr, 7'd1);
    wait_done(400);

    // Randomized songs with random pause and stray start pulses.
    for (int s = 0; s < 8; s++) begin
      for (int j = 0; j < SONG_LEN; j++) mem[j] = 4'($urandom_range(0, 15));
      step(1'b1, 1'b0);
      for (int c = 0; c < 3000 && m_mode != M_DONE; c++) begin
        step(1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 9) == 0));
      end
      check_eq("random_song_done", done, 1'b1);
      check_eq("random_song_track", track, 8'h00);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
